// File: rtl/ram_fetch_pkg.sv
// rtl/ram_fetch_pkg.sv - Shared widths, FSM state enum and point-index type for the point reader.
package ram_fetch_pkg;

    localparam int RF_ADDR_WIDTH  = 14;
    localparam int RF_DATA_WIDTH  = 32;
    localparam int RF_LENGTH      = 16;
    localparam int RF_LEN_BITS    = 4;
    localparam int RF_FIFO_DEPTH  = 2;
    localparam int RF_POINT_WIDTH = RF_ADDR_WIDTH - RF_LEN_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef logic [RF_POINT_WIDTH-1:0] point_t;

endpackage

// File: rtl/ram_point_reader_if.sv
// rtl/ram_point_reader_if.sv - Request, RAM bus and feature stream signals; sum outputs exist only with POINT_SUM_EN.
interface ram_point_reader_if #(
    parameter int ADDR_WIDTH = ram_fetch_pkg::RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = ram_fetch_pkg::RF_DATA_WIDTH,
    parameter int LEN_BITS   = ram_fetch_pkg::RF_LEN_BITS
);

    logic                         req_valid;
    logic                         req_ready;
    logic [ADDR_WIDTH-LEN_BITS-1:0] req_point;

    logic                         ram_cs;
    logic                         ram_we;
    logic                         ram_oe;
    logic [ADDR_WIDTH-1:0]        ram_addr;
    logic [DATA_WIDTH-1:0]        ram_data;

    logic                         feat_valid;
    logic                         feat_ready;
    logic [DATA_WIDTH-1:0]        feat_data;
    logic [LEN_BITS-1:0]          feat_idx;
    logic                         feat_last;

    logic                         busy;

`ifdef POINT_SUM_EN
    logic                         sum_valid;
    logic [DATA_WIDTH+LEN_BITS-1:0] sum_data;

    modport master (
        input  req_valid, req_point, ram_data, feat_ready,
        output req_ready, ram_cs, ram_we, ram_oe, ram_addr,
               feat_valid, feat_data, feat_idx, feat_last, busy,
               sum_valid, sum_data
    );

    modport slave (
        output req_valid, req_point, ram_data, feat_ready,
        input  req_ready, ram_cs, ram_we, ram_oe, ram_addr,
               feat_valid, feat_data, feat_idx, feat_last, busy,
               sum_valid, sum_data
    );
`else
    modport master (
        input  req_valid, req_point, ram_data, feat_ready,
        output req_ready, ram_cs, ram_we, ram_oe, ram_addr,
               feat_valid, feat_data, feat_idx, feat_last, busy
    );

    modport slave (
        output req_valid, req_point, ram_data, feat_ready,
        input  req_ready, ram_cs, ram_we, ram_oe, ram_addr,
               feat_valid, feat_data, feat_idx, feat_last, busy
    );
`endif

endinterface

// File: rtl/fetch_skid_fifo.sv
// rtl/fetch_skid_fifo.sv - Small synchronous FIFO absorbing read data under backpressure; count feeds the issue credit check.
module fetch_skid_fifo #(
    parameter  int WIDTH = 37,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Empty FIFO presents zeros so the stream outputs read as idle.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ram_point_reader.sv
// rtl/ram_point_reader.sv - Reads LENGTH feature words of one point from RAM and streams them out; POINT_SUM_EN adds a per-point sum.
module ram_point_reader
    import ram_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int LENGTH     = RF_LENGTH,
    parameter int LEN_BITS   = RF_LEN_BITS,
    parameter int FIFO_DEPTH = RF_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_point_reader_if.master  bus
);

    localparam int PW    = ADDR_WIDTH - LEN_BITS;
    localparam int EW    = DATA_WIDTH + LEN_BITS + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CW    = CNT_W + 1;
    localparam logic [LEN_BITS-1:0] LAST_IDX = LEN_BITS'(LENGTH - 1);

    fetch_state_e          state_q, state_d;
    logic [PW-1:0]         point_q, point_d;
    logic [LEN_BITS-1:0]   issue_idx_q, issue_idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  dphase_q, dphase_d;
    logic [LEN_BITS-1:0]   dphase_idx_q, dphase_idx_d;

    logic                  issue;
    logic                  req_ready_c;
    logic [ADDR_WIDTH-1:0] issue_addr;

    logic [EW-1:0]         push_entry;
    logic [EW-1:0]         head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  h_last;
    logic [LEN_BITS-1:0]   h_idx;
    logic [DATA_WIDTH-1:0] h_data;
    logic                  feat_valid;
    logic                  pop;
    logic [CW-1:0]         occupancy;
    logic                  credit_ok;

    assign issue_addr = {point_q, issue_idx_q};
    assign {h_last, h_idx, h_data} = head;
    assign feat_valid = ~fifo_empty;
    assign pop        = feat_valid & bus.feat_ready;

    // A slot is reserved for every read in flight so the FIFO can never overflow.
    assign occupancy = CW'(fifo_count) + CW'(dphase_q);
    assign credit_ok = (occupancy - CW'(pop)) < CW'(FIFO_DEPTH);

    always_comb begin
        state_d      = state_q;
        point_d      = point_q;
        issue_idx_d  = issue_idx_q;
        addr_d       = addr_q;
        dphase_d     = 1'b0;
        dphase_idx_d = dphase_idx_q;
        issue        = 1'b0;
        req_ready_c  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    point_d     = bus.req_point;
                    issue_idx_d = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (credit_ok) begin
                    issue        = 1'b1;
                    addr_d       = issue_addr;
                    dphase_d     = 1'b1;
                    dphase_idx_d = issue_idx_q;
                    issue_idx_d  = issue_idx_q + LEN_BITS'(1);
                    if (issue_idx_q == LAST_IDX) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && h_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            point_q      <= '0;
            issue_idx_q  <= '0;
            addr_q       <= '0;
            dphase_q     <= 1'b0;
            dphase_idx_q <= '0;
        end else begin
            state_q      <= state_d;
            point_q      <= point_d;
            issue_idx_q  <= issue_idx_d;
            addr_q       <= addr_d;
            dphase_q     <= dphase_d;
            dphase_idx_q <= dphase_idx_d;
        end
    end

    // Data-only cycles repeat the last address so the RAM reload is harmless.
    assign push_entry = {(dphase_idx_q == LAST_IDX), dphase_idx_q, bus.ram_data};

    fetch_skid_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (dphase_q),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign bus.req_ready  = req_ready_c;
    assign bus.ram_cs     = issue | dphase_q;
    assign bus.ram_oe     = dphase_q;
    assign bus.ram_we     = 1'b0;
    assign bus.ram_addr   = issue ? issue_addr : addr_q;
    assign bus.feat_valid = feat_valid;
    assign bus.feat_data  = h_data;
    assign bus.feat_idx   = h_idx;
    assign bus.feat_last  = h_last;
    assign bus.busy       = (state_q != IDLE);

`ifdef POINT_SUM_EN
    localparam int SW = DATA_WIDTH + LEN_BITS;

    logic [SW-1:0] acc_q;
    logic          sum_valid_q;
    logic          accept;

    assign accept = (state_q == IDLE) & bus.req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            if (accept)   acc_q <= '0;
            else if (pop) acc_q <= acc_q + SW'(h_data);
            sum_valid_q <= pop & h_last;
        end
    end

    assign bus.sum_valid = sum_valid_q;
    assign bus.sum_data  = acc_q;
`endif

endmodule

// File: tb/tb_ram_point_reader.sv
// tb/tb_ram_point_reader.sv - Self-checking bench: RAM model, per-scenario tasks, random stimulus vs point/feature reference.
module tb_ram_point_reader;
    import ram_fetch_pkg::*;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int LB  = 4;
    localparam int LEN = 16;
    localparam int FD  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_point_reader_if bus ();

    ram_point_reader #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .LENGTH (LEN), .LEN_BITS (LB), .FIFO_DEPTH (FD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM: latches the address on any selected edge, drives data while cs & oe.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] ram_lat;
    always @(posedge clk) if (bus.ram_cs) ram_lat <= bus.ram_addr;
    assign bus.ram_data = (bus.ram_cs && bus.ram_oe) ? mem[ram_lat] : 32'hDEAD_BEEF;

    // Bus monitor: a read is a selected cycle that is not a repeat of the held address.
    logic [AW-1:0] issue_log[$];
    logic [AW-1:0] last_cs_addr = '0;
    int            we_seen = 0;
    always @(negedge clk) begin
        #2;
        if (bus.ram_we !== 1'b0) we_seen++;
        if (bus.ram_cs === 1'b1) begin
            if (!bus.ram_oe || bus.ram_addr != last_cs_addr) issue_log.push_back(bus.ram_addr);
            last_cs_addr = bus.ram_addr;
        end
    end

    logic [DW-1:0] got_data[$];
    logic [LB-1:0] got_idx[$];
    logic          got_last[$];
    int            got_cyc[$];
    int            hold_viol;

    function automatic logic [DW-1:0] ref_word(input int p, input int k);
        logic [AW-1:0] a;
        a = AW'(p * LEN + k);
        return mem[a];
    endfunction

    task automatic send_req(input int p, output int acc_cyc);
        bit ok;
        ok = 0;
        acc_cyc = -1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_point = p[9:0];
        for (int i = 0; i < 60; i++) begin
            #1;
            if (bus.req_ready === 1'b1) begin
                @(negedge clk);
                bus.req_valid = 1'b0;
                acc_cyc = cyc;
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            bus.req_valid = 1'b0;
            $display("FAIL req_accept point %0d: req_ready never 1, required acceptance", p);
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: toggle ready. Returns at the negedge after feat_last handshake.
    task automatic stream(input int mode, input int budget, output bit done);
        bit            pv;
        logic [DW+LB:0] pvals;
        got_data.delete(); got_idx.delete(); got_last.delete(); got_cyc.delete();
        hold_viol = 0; done = 0; pv = 0; pvals = '0;
        for (int c = 0; c < budget; c++) begin
            case (mode)
                0:       bus.feat_ready = 1'b1;
                1:       bus.feat_ready = ($urandom_range(0, 3) != 0);
                default: bus.feat_ready = ~bus.feat_ready;
            endcase
            #1;
            if (pv && !(bus.feat_valid && {bus.feat_last, bus.feat_idx, bus.feat_data} == pvals)) hold_viol++;
            pv    = bus.feat_valid && !bus.feat_ready;
            pvals = {bus.feat_last, bus.feat_idx, bus.feat_data};
            if (bus.feat_valid && bus.feat_ready) begin
                got_data.push_back(bus.feat_data);
                got_idx.push_back(bus.feat_idx);
                got_last.push_back(bus.feat_last);
                got_cyc.push_back(cyc);
                if (bus.feat_last) done = 1;
            end
            @(negedge clk);
            if (done) break;
        end
        bus.feat_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.ram_cs, bus.ram_oe, bus.ram_we, bus.ram_addr} !== '0) begin
            errors++;
            $display("FAIL reset_ram cs=%b oe=%b we=%b addr=%h required all 0", bus.ram_cs, bus.ram_oe, bus.ram_we, bus.ram_addr);
        end
        checks++;
        if ({bus.feat_valid, bus.feat_data, bus.feat_idx, bus.feat_last} !== '0) begin
            errors++;
            $display("FAIL reset_feat valid=%b data=%h idx=%0d last=%b required all 0", bus.feat_valid, bus.feat_data, bus.feat_idx, bus.feat_last);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b required 1", bus.req_ready); end
    endtask

    task automatic test_point5();
        int acc; bit done;
        for (int k = 0; k < LEN; k++) mem[5*LEN + k] = 32'h1000 + k;
        issue_log.delete();
        send_req(5, acc);
        stream(0, 40, done);
        checks++;
        if (!done || got_data.size() != LEN) begin
            errors++; $display("FAIL p5_count got %0d beats required %0d", got_data.size(), LEN);
        end
        for (int k = 0; k < LEN; k++) begin
            checks++;
            if (got_data[k] !== 32'h1000 + k || got_idx[k] !== LB'(k) || got_last[k] !== (k == LEN-1)) begin
                errors++;
                $display("FAIL p5_beat%0d got %h/%0d/%b required %h/%0d/%b", k, got_data[k], got_idx[k], got_last[k], 32'h1000 + k, k, k == LEN-1);
            end
        end
        checks++;
        if (got_cyc.size() == 0 || got_cyc[0] != acc + 2) begin
            errors++; $display("FAIL p5_latency first beat cycle %0d required %0d", got_cyc.size() ? got_cyc[0] : -1, acc + 2);
        end
        checks++;
        if (got_cyc.size() != LEN || got_cyc[LEN-1] - got_cyc[0] != LEN - 1) begin
            errors++; $display("FAIL p5_no_bubbles span %0d required %0d", got_cyc.size() ? got_cyc[got_cyc.size()-1] - got_cyc[0] : -1, LEN - 1);
        end
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL p5_idle_after busy=%b req_ready=%b required 0/1", bus.busy, bus.req_ready);
        end
    endtask

    task automatic test_point1023();
        int acc; bit done;
        for (int k = 0; k < LEN; k++) mem[1023*LEN + k] = 32'hFFFF_FF00 + k;
        issue_log.delete();
        send_req(1023, acc);
        stream(1, 100, done);
        checks++;
        if (issue_log.size() != LEN) begin
            errors++; $display("FAIL p1023_reads got %0d required %0d", issue_log.size(), LEN);
        end
        for (int k = 0; k < LEN; k++) begin
            checks++;
            if (issue_log[k] !== AW'(14'h3FF0 + k) || got_data[k] !== 32'hFFFF_FF00 + k || got_idx[k] !== LB'(k)) begin
                errors++;
                $display("FAIL p1023_beat%0d addr %h data %h idx %0d required %h %h %0d", k, issue_log[k], got_data[k], got_idx[k], 14'h3FF0 + k, 32'hFFFF_FF00 + k, k);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc, p; bit done;
        p = $urandom_range(0, 1022);
        issue_log.delete();
        send_req(p, acc);
        for (int i = 0; i < 20; i++) begin
            bus.feat_ready = 1'b0;
            #1;
            @(negedge clk);
        end
        #1;
        checks++;
        if (issue_log.size() != FD || bus.ram_cs !== 1'b0) begin
            errors++; $display("FAIL bp_stall_reads got %0d cs=%b required %0d cs=0", issue_log.size(), bus.ram_cs, FD);
        end
        checks++;
        if (bus.feat_valid !== 1'b1 || bus.feat_data !== ref_word(p, 0) || bus.feat_idx !== '0) begin
            errors++; $display("FAIL bp_head valid=%b data=%h idx=%0d required 1 %h 0", bus.feat_valid, bus.feat_data, bus.feat_idx, ref_word(p, 0));
        end
        stream(2, 100, done);
        checks++;
        if (!done || got_data.size() != LEN || hold_viol != 0) begin
            errors++; $display("FAIL bp_stream beats %0d hold_viol %0d required %0d 0", got_data.size(), hold_viol, LEN);
        end
        for (int k = 0; k < LEN; k++) begin
            checks++;
            if (got_data[k] !== ref_word(p, k) || got_idx[k] !== LB'(k) || got_last[k] !== (k == LEN-1)) begin
                errors++; $display("FAIL bp_beat%0d got %h/%0d required %h/%0d", k, got_data[k], got_idx[k], ref_word(p, k), k);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_acc, first_last_cyc, acc2_cyc, total;
        n_acc = 0; first_last_cyc = -1; acc2_cyc = -1; total = 0;
        got_data.delete(); got_idx.delete(); got_last.delete();
        we_seen = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_point = 10'd2;
        for (int c = 0; c < 300; c++) begin
            bus.feat_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (bus.req_valid && bus.req_ready) begin
                n_acc++;
                if (n_acc == 2) acc2_cyc = cyc;
            end
            if (bus.feat_valid && bus.feat_ready) begin
                got_data.push_back(bus.feat_data);
                got_idx.push_back(bus.feat_idx);
                got_last.push_back(bus.feat_last);
                if (bus.feat_last && first_last_cyc < 0) first_last_cyc = cyc;
            end
            @(negedge clk);
            if (n_acc == 1) bus.req_point = 10'd3;
            if (n_acc >= 2) bus.req_valid = 1'b0;
            if (got_data.size() == 2*LEN) break;
        end
        bus.req_valid = 1'b0;
        bus.feat_ready = 1'b1;
        checks++;
        if (acc2_cyc != first_last_cyc + 1 || first_last_cyc < 0) begin
            errors++; $display("FAIL b2b_second_accept cycle %0d required %0d", acc2_cyc, first_last_cyc + 1);
        end
        checks++;
        if (got_data.size() != 2*LEN) begin
            errors++; $display("FAIL b2b_count got %0d required %0d", got_data.size(), 2*LEN);
        end
        for (int k = 0; k < 2*LEN; k++) begin
            checks++;
            if (got_data[k] !== ref_word(2 + k/LEN, k%LEN) || got_idx[k] !== LB'(k%LEN) || got_last[k] !== ((k%LEN) == LEN-1)) begin
                errors++; $display("FAIL b2b_beat%0d got %h/%0d required %h/%0d", k, got_data[k], got_idx[k], ref_word(2 + k/LEN, k%LEN), k%LEN);
            end
        end
        checks++;
        if (we_seen != 0) begin errors++; $display("FAIL ram_we_high seen %0d cycles required 0", we_seen); end
    endtask

    task automatic test_reset_mid();
        int acc, p; bit hit, done;
        p = $urandom_range(0, 1022);
        hit = 0;
        send_req(p, acc);
        for (int c = 0; c < 40; c++) begin
            bus.feat_ready = 1'b1;
            #1;
            if (bus.feat_valid && bus.feat_idx == 4'd7) begin
                #1;
                rst_n = 1'b0;
                #1;
                hit = 1;
                checks++;
                if ({bus.feat_valid, bus.feat_data, bus.feat_idx, bus.feat_last, bus.busy, bus.ram_cs, bus.ram_oe, bus.ram_addr} !== '0) begin
                    errors++;
                    $display("FAIL midreset_outputs valid=%b data=%h idx=%0d busy=%b cs=%b oe=%b addr=%h required all 0",
                             bus.feat_valid, bus.feat_data, bus.feat_idx, bus.busy, bus.ram_cs, bus.ram_oe, bus.ram_addr);
                end
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midreset_beat7 never reached, required beat 7"); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_req(9, acc);
        stream(1, 120, done);
        checks++;
        if (!done || got_data.size() != LEN) begin
            errors++; $display("FAIL midreset_p9_count got %0d required %0d", got_data.size(), LEN);
        end
        for (int k = 0; k < LEN; k++) begin
            checks++;
            if (got_data[k] !== ref_word(9, k) || got_idx[k] !== LB'(k)) begin
                errors++; $display("FAIL midreset_p9_beat%0d got %h/%0d required %h/%0d", k, got_data[k], got_idx[k], ref_word(9, k), k);
            end
        end
    endtask

    task automatic test_random_points();
        int acc, p; bit done;
        for (int r = 0; r < 4; r++) begin
            p = $urandom_range(0, 1023);
            send_req(p, acc);
            stream(1, 150, done);
            checks++;
            if (!done || got_data.size() != LEN || hold_viol != 0) begin
                errors++; $display("FAIL rand%0d_stream beats %0d hold_viol %0d required %0d 0", r, got_data.size(), hold_viol, LEN);
            end
            for (int k = 0; k < LEN; k++) begin
                checks++;
                if (got_data[k] !== ref_word(p, k) || got_idx[k] !== LB'(k) || got_last[k] !== (k == LEN-1)) begin
                    errors++; $display("FAIL rand%0d_beat%0d got %h/%0d required %h/%0d", r, k, got_data[k], got_idx[k], ref_word(p, k), k);
                end
            end
        end
    endtask

`ifdef POINT_SUM_EN
    task automatic test_sum();
        int acc, p, pulses, pulse_cyc, last_cyc;
        logic [DW+LB-1:0] pulse_sum, exp_sum;
        for (int r = 0; r < 2; r++) begin
            p = $urandom_range(0, 1023);
            exp_sum = '0;
            for (int k = 0; k < LEN; k++) begin
                if (r == 0) mem[p*LEN + k] = 32'hFFFF_FFFF;
                exp_sum = exp_sum + ref_word(p, k);
            end
            if (r == 0) exp_sum = 36'hF_FFFF_FFF0;
            pulses = 0; pulse_cyc = -1; last_cyc = -1; pulse_sum = '0;
            send_req(p, acc);
            for (int c = 0; c < 150; c++) begin
                bus.feat_ready = ($urandom_range(0, 1) != 0);
                #1;
                if (bus.sum_valid === 1'b1) begin pulses++; pulse_cyc = cyc; pulse_sum = bus.sum_data; end
                if (bus.feat_valid && bus.feat_ready && bus.feat_last) last_cyc = cyc;
                @(negedge clk);
                if (last_cyc >= 0 && cyc > last_cyc + 3) break;
            end
            bus.feat_ready = 1'b1;
            checks++;
            if (pulses != 1 || pulse_cyc != last_cyc + 1) begin
                errors++; $display("FAIL sum%0d_pulse count %0d at %0d required 1 at %0d", r, pulses, pulse_cyc, last_cyc + 1);
            end
            checks++;
            if (pulse_sum !== exp_sum) begin
                errors++; $display("FAIL sum%0d_value got %h required %h", r, pulse_sum, exp_sum);
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_point  = '0;
        bus.feat_ready = 1'b1;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        test_reset();
        test_point5();
        test_point1023();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random_points();
`ifdef POINT_SUM_EN
        test_sum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
